// File: rtl/xorexec_pkg.sv
// Shared xorexec types and constants: feeder FSM states, datapath width, smallest legal idata.
package xorexec_pkg;

    localparam int XOREXEC_DWIDTH = 8;
    localparam logic [XOREXEC_DWIDTH-1:0] XOREXEC_MIN_DATA = 8'h04;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GAP   = 2'd2
    } feeder_state_e;

    function automatic logic [XOREXEC_DWIDTH-1:0] clamp_min(
        input logic [XOREXEC_DWIDTH-1:0] d,
        input logic [XOREXEC_DWIDTH-1:0] lo
    );
        return (d < lo) ? lo : d;
    endfunction

endpackage

// File: rtl/xorexec_sync_fifo.sv
// Generic synchronous FIFO; head is the combinational view of the oldest entry.
// Write is ignored while full even when a read happens in the same cycle.
module xorexec_sync_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd,
    output logic              full,
    output logic              empty,
    output logic [DWIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              wr_en;
    logic              rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/xorexec_ififo_feeder.sv
// Filters a valid/ready byte stream, buffers it and pushes into the xorexec input FIFO (XOREXEC_FEEDER_CLAMP_EN clamps instead of dropping).
// Latency: accept N -> staged N+1 -> push N+2; at most one push every other cycle.
// Backpressure: in_ready falls when the buffer is full; ififo_not_full low holds the staged byte indefinitely.
module xorexec_ififo_feeder
    import xorexec_pkg::*;
#(
    parameter int                DWIDTH   = XOREXEC_DWIDTH,
    parameter int                DEPTH    = 4,
    parameter logic [DWIDTH-1:0] MIN_DATA = DWIDTH'(XOREXEC_MIN_DATA)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              ififo_not_full,
    output logic              ififo_push,
    output logic [DWIDTH-1:0] idata,
    output logic [15:0]       drop_cnt,
    output logic              busy
);
    feeder_state_e     state;
    feeder_state_e     state_nxt;
    logic              rst;
    logic              accept;
    logic              below;
    logic              buf_wr;
    logic [DWIDTH-1:0] buf_wdata;
    logic              buf_full;
    logic              buf_empty;
    logic [DWIDTH-1:0] buf_head;
    logic              load;
    logic              push;

    assign rst      = !rst_n;
    assign in_ready = !buf_full || !rst_n;
    assign accept   = in_valid && in_ready;
    assign below    = (in_data < MIN_DATA);

`ifdef XOREXEC_FEEDER_CLAMP_EN
    assign buf_wr    = accept;
    assign buf_wdata = below ? MIN_DATA : in_data;
`else
    assign buf_wr    = accept && !below;
    assign buf_wdata = in_data;
`endif

    xorexec_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .wr    (buf_wr),
        .wdata (buf_wdata),
        .rd    (load),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // GAP exists solely so two pushes never land on adjacent cycles.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (!buf_empty) begin
                    load      = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                push = ififo_not_full;
                if (ififo_not_full) state_nxt = GAP;
            end
            GAP: begin
                if (!buf_empty) begin
                    load      = 1'b1;
                    state_nxt = ARMED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ififo_push = push && rst_n;
    assign busy       = rst_n && (!buf_empty || (state != IDLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idata <= MIN_DATA;
        end else if (load) begin
            idata <= buf_head;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && below && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_xorexec_ififo_feeder.sv
// Bench for xorexec_ififo_feeder: vector table, hand-written corner sequences and a randomized run against a queue model.
module tb_xorexec_ififo_feeder;
    import xorexec_pkg::*;

    localparam logic [7:0] MIN = 8'h04;
`ifdef XOREXEC_FEEDER_CLAMP_EN
    localparam int T4_PUSHES = 4;
`else
    localparam int T4_PUSHES = 2;
`endif
    localparam int RAND_BYTES = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        ififo_not_full;
    logic        ififo_push;
    logic [7:0]  idata;
    logic [15:0] drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    xorexec_ififo_feeder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .ififo_not_full (ififo_not_full),
        .ififo_push     (ififo_push),
        .idata          (idata),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    a_push_nf: assert property (@(posedge clk) disable iff (!rst_n) ififo_push |-> ififo_not_full)
        else $error("FAIL sva_push_without_not_full");
    a_no_b2b: assert property (@(posedge clk) disable iff (!rst_n) ififo_push |=> !ififo_push)
        else $error("FAIL sva_back_to_back_push");
    a_min: assert property (@(posedge clk) disable iff (!rst_n) idata >= MIN)
        else $error("FAIL sva_idata_below_min");

    typedef struct {
        logic [7:0] din;
        bit         exp_push;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs [7];
    int         checks;
    int         errors;
    logic [7:0] exp_q [$];
    int         model_drops;
    int         push_cnt;
    bit         prev_push;
    bit         saw_not_ready;
    bit         acc;
    int         sent;
    int         pc0;
    int         dr0;
    logic [7:0] prev_idata;
    logic [7:0] rnd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: every byte >= MIN goes out unchanged and in order; smaller bytes are counted and dropped (or clamped).
    function automatic void model_accept(input logic [7:0] d);
        if (d < MIN) begin
            if (model_drops < 65535) model_drops++;
`ifdef XOREXEC_FEEDER_CLAMP_EN
            exp_q.push_back(MIN);
`endif
        end else begin
            exp_q.push_back(d);
        end
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_no_push", 32'(ififo_push), 32'(0));
                prev_push = 1'b0;
            end else begin
                chk("idata_ge_min", 32'(idata >= MIN), 32'(1));
                if (ififo_push) begin
                    chk("push_needs_not_full", 32'(ififo_not_full), 32'(1));
                    chk("no_back_to_back", 32'(prev_push), 32'(0));
                    chk("push_expected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) chk("push_order", 32'(idata), 32'(exp_q.pop_front()));
                    push_cnt++;
                end
                if (!in_ready) saw_not_ready = 1'b1;
                prev_push = ififo_push;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called and returns just after a rising edge; the byte is accepted at the first edge with in_ready high.
    task automatic send(input logic [7:0] d);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'(1));
        end else begin
            model_accept(d);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        ififo_not_full = 1'b1;
        while (busy && w < 200) begin
            tick();
            w++;
        end
        chk("drain_idle", 32'(busy), 32'(0));
        chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 8'h55};
        vecs[1] = '{8'h04, 1'b1, 8'h04};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF};
`ifdef XOREXEC_FEEDER_CLAMP_EN
        vecs[3] = '{8'h00, 1'b1, 8'h04};
        vecs[4] = '{8'h03, 1'b1, 8'h04};
`else
        vecs[3] = '{8'h00, 1'b0, 8'h00};
        vecs[4] = '{8'h03, 1'b0, 8'h00};
`endif
        vecs[5] = '{8'h05, 1'b1, 8'h05};
        vecs[6] = '{8'h80, 1'b1, 8'h80};

        checks = 0; errors = 0; model_drops = 0; push_cnt = 0;
        prev_push = 1'b0; saw_not_ready = 1'b0; acc = 1'b0; sent = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ififo_not_full = 1'b1;

        fork
            monitor();
        join_none

        // T1 reset
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_push", 32'(ififo_push), 32'(0));
        tick();
        tick();
        chk("rst_idata", 32'(idata), 32'(MIN));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idata", 32'(idata), 32'(MIN));
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_busy", 32'(busy), 32'(0));
        tick();

        // T2 + single-byte vectors: exact push cycle and idata hold on filtered bytes
        prev_idata = MIN;
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].din);
            @(negedge clk);
            chk($sformatf("vec%0d_c1_push", i), 32'(ififo_push), 32'(0));
            @(negedge clk);
            chk($sformatf("vec%0d_c2_push", i), 32'(ififo_push), 32'(vecs[i].exp_push));
            chk($sformatf("vec%0d_c2_idata", i), 32'(idata),
                32'(vecs[i].exp_push ? vecs[i].exp_data : prev_idata));
            @(negedge clk);
            chk($sformatf("vec%0d_c3_push", i), 32'(ififo_push), 32'(0));
            chk($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(model_drops));
            if (vecs[i].exp_push) prev_idata = vecs[i].exp_data;
            tick();
            drain();
        end

        // T3 burst
        pc0 = push_cnt;
        saw_not_ready = 1'b0;
        for (int b = 0; b < 8; b++) send(8'h10 + 8'(b));
        drain();
        chk("burst_pushes", 32'(push_cnt - pc0), 32'(8));
        chk("burst_in_ready_dropped", 32'(saw_not_ready), 32'(1));

        // T4 filter
        pc0 = push_cnt;
        dr0 = model_drops;
        send(8'h00);
        send(8'h03);
        send(8'h04);
        send(8'hFF);
        drain();
        chk("filter_pushes", 32'(push_cnt - pc0), 32'(T4_PUSHES));
        chk("filter_drop_cnt", 32'(drop_cnt), 32'(dr0 + 2));

        // T5 backpressure while ARMED
        ififo_not_full = 1'b0;
        send(8'hA7);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_no_push", 32'(ififo_push), 32'(0));
            chk("bp_idata_hold", 32'(idata), 32'(8'hA7));
            chk("bp_busy", 32'(busy), 32'(1));
            @(negedge clk);
        end
        tick();
        ififo_not_full = 1'b1;
        @(negedge clk);
        chk("bp_release_push", 32'(ififo_push), 32'(1));
        chk("bp_release_idata", 32'(idata), 32'(8'hA7));
        tick();
        drain();

        // T6 reset with one byte staged and three buffered
        ififo_not_full = 1'b0;
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        send(8'hC4);
        rst_n = 1'b0;
        exp_q.delete();
        model_drops = 0;
        @(negedge clk);
        chk("midrst_push", 32'(ififo_push), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        tick();
        tick();
        rst_n = 1'b1;
        ififo_not_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("after_rst_no_push", 32'(ififo_push), 32'(0));
            chk("after_rst_busy", 32'(busy), 32'(0));
        end
        chk("after_rst_idata", 32'(idata), 32'(MIN));
        chk("after_rst_drop_cnt", 32'(drop_cnt), 32'(0));
        tick();

        // Randomized traffic with random downstream backpressure
        acc = 1'b0;
        sent = 0;
        for (int c = 0; c < 20000 && sent < RAND_BYTES; c++) begin
            if (acc) in_valid = 1'b0;
            ififo_not_full = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 3) == 0) rnd = 8'($urandom_range(0, 7));
                else                           rnd = 8'($urandom_range(0, 255));
                in_valid = 1'b1;
                in_data  = rnd;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                model_accept(in_data);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("rand_all_sent", 32'(sent), 32'(RAND_BYTES));
        drain();
        chk("rand_drop_cnt", 32'(drop_cnt), 32'(model_drops));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
